// File: rtl/inner_pipe.sv
// Streaming fixed-point dot-product engine: LANES multiplies per beat, BEATS beats per vector,
// with a three-stage pipeline (products, lane sum, accumulate/saturate) and ready/valid flow control.
module inner_pipe #(
    parameter int DATA_LEN = 16,
    parameter int LANES    = 36,
    parameter int BEATS    = 4,
    parameter int FRAC     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_LEN-1:0] d1,
    input  logic [LANES*DATA_LEN-1:0] d2,
    output logic [DATA_LEN-1:0]       q,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int PROD_W = 2 * DATA_LEN;
    localparam int ACC_W  = 2 * DATA_LEN + $clog2(LANES * BEATS);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic signed [ACC_W-1:0] Q_MAX =
        ACC_W'((longint'(1) <<< (DATA_LEN - 1)) - longint'(1));
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    logic stall;
    logic accept;

    // Stage 1: per-lane products plus the beat tag
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     s1_valid_d, s1_valid_q;
    logic [CNT_W-1:0]         s1_cnt_d, s1_cnt_q;
    logic                     s1_relu_d, s1_relu_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;

    // Stage 2: lane sum
    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0]  s2_sum_d, s2_sum_q;
    logic                     s2_valid_d, s2_valid_q;
    logic [CNT_W-1:0]         s2_cnt_d, s2_cnt_q;
    logic                     s2_relu_d, s2_relu_q;

    // Stage 3: accumulator and result register
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  total;
    logic signed [ACC_W-1:0]  r;
    logic [DATA_LEN-1:0]      q_sat;
    logic [DATA_LEN-1:0]      q_d, q_q;
    logic                     out_valid_d, out_valid_q;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && !stall && !clear;
    assign q         = q_q;
    assign out_valid = out_valid_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = prod_q[i];
            if (accept) begin
                prod_d[i] = PROD_W'($signed(d1[i*DATA_LEN +: DATA_LEN]))
                          * PROD_W'($signed(d2[i*DATA_LEN +: DATA_LEN]));
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        s1_relu_d  = s1_relu_q;
        if (clear) begin
            cnt_d      = '0;
            s1_valid_d = 1'b0;
        end else if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_cnt_d  = cnt_q;
                s1_relu_d = relu;
                cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + ACC_W'(prod_q[i]);
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_cnt_d   = s2_cnt_q;
        s2_relu_d  = s2_relu_q;
        s2_sum_d   = s2_sum_q;
        if (clear) begin
            s2_valid_d = 1'b0;
        end else if (!stall) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_cnt_d  = s1_cnt_q;
                s2_relu_d = s1_relu_q;
                s2_sum_d  = lane_sum;
            end
        end
    end

    // Beat 0 starts a fresh vector, so the stale accumulator is ignored rather than cleared early
    always_comb begin
        acc_base = (s2_cnt_q == '0) ? '0 : acc_q;
        total    = acc_base + s2_sum_q;
        r        = total >>> FRAC;
        if (s2_relu_q && (r < 0)) begin
            q_sat = '0;
        end else if (r > Q_MAX) begin
            q_sat = Q_MAX[DATA_LEN-1:0];
        end else if (r < Q_MIN) begin
            q_sat = Q_MIN[DATA_LEN-1:0];
        end else begin
            q_sat = r[DATA_LEN-1:0];
        end
    end

    always_comb begin
        acc_d       = acc_q;
        q_d         = q_q;
        out_valid_d = out_valid_q && !out_ready;
        if (clear) begin
            acc_d = '0;
        end else if (!stall && s2_valid_q) begin
            if (s2_cnt_q == LAST) begin
                acc_d       = '0;
                q_d         = q_sat;
                out_valid_d = 1'b1;
            end else begin
                acc_d = total;
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q   <= prod_d;
        s2_sum_q <= s2_sum_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_cnt_q    <= '0;
            s1_relu_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_cnt_q    <= '0;
            s2_relu_q   <= 1'b0;
            acc_q       <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_cnt_q    <= s1_cnt_d;
            s1_relu_q   <= s1_relu_d;
            s2_valid_q  <= s2_valid_d;
            s2_cnt_q    <= s2_cnt_d;
            s2_relu_q   <= s2_relu_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_inner_pipe.sv
// Bench for inner_pipe: directed scenarios plus randomized vectors scored against a
// vector-level dot-product model with a FIFO of expected results.
module tb_inner_pipe;

    localparam int DL = 16;
    localparam int LN = 36;
    localparam int BT = 4;
    localparam int FR = 8;
    localparam int W  = DL * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          relu;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic [DL-1:0] q;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    inner_pipe #(.DATA_LEN(DL), .LANES(LN), .BEATS(BT), .FRAC(FR)) dut (
        .clk(clk), .rst(rst), .clear(clear), .relu(relu),
        .in_valid(in_valid), .in_ready(in_ready), .d1(d1), .d2(d2),
        .q(q), .out_valid(out_valid), .out_ready(out_ready)
    );

    int            checks = 0;
    int            errors = 0;
    longint        partial = 0;
    int            beat_idx = 0;
    logic [DL-1:0] exp_q[$];
    bit            last_accept;
    bit            prev_stall = 1'b0;
    logic [DL-1:0] prev_q;
    int            results_seen = 0;
    int            stall_cycles = 0;
    int            ready_mode = 0;   // 0: always ready, 1: random, 2: manual
    bit            arm_hold = 1'b0;
    int            hold_left = 0;
    logic [W-1:0]  ones;
    logic [W-1:0]  zero_v;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint dot(input logic [W-1:0] a, input logic [W-1:0] b);
        longint s = 0;
        logic signed [DL-1:0] x, y;
        for (int i = 0; i < LN; i++) begin
            x = a[i*DL +: DL];
            y = b[i*DL +: DL];
            s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    function automatic logic [DL-1:0] expect_q(input longint tot, input bit rl);
        longint r = tot >>> FR;
        longint mx = (longint'(1) <<< (DL - 1)) - 1;
        if (rl && r < 0) return '0;
        if (r > mx) r = mx;
        if (r < -mx - 1) r = -mx - 1;
        return r[DL-1:0];
    endfunction

    function automatic logic [W-1:0] lane0(input logic [DL-1:0] x);
        logic [W-1:0] v = '0;
        v[DL-1:0] = x;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        logic signed [DL-1:0] e;
        for (int i = 0; i < LN; i++) begin
            e = DL'($urandom);
            e = e >>> $urandom_range(0, 14);
            v[i*DL +: DL] = e;
        end
        return v;
    endfunction

    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit rl);
        partial += dot(a, b);
        beat_idx++;
        if (beat_idx == BT) begin
            exp_q.push_back(expect_q(partial, rl));
            partial  = 0;
            beat_idx = 0;
        end
    endtask

    // One clock: observe/score at the falling edge, then step past the rising edge
    task automatic tick();
        logic [DL-1:0] e;
        @(negedge clk);
        if (!rst) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (!in_ready) stall_cycles++;
            if (prev_stall) begin
                chk("stall_hold_q", {48'd0, q}, {48'd0, prev_q});
                chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_result: got %h expected none", q);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("result", {48'd0, q}, {48'd0, e});
                end
                results_seen++;
            end
            last_accept = in_valid && in_ready && !clear;
            if (last_accept) model_beat(d1, d2, relu);
            if (clear) begin
                partial  = 0;
                beat_idx = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_q     = q;
        end else begin
            last_accept = 1'b0;
            prev_stall  = 1'b0;
            partial     = 0;
            beat_idx    = 0;
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        if (arm_hold && out_valid) begin
            arm_hold  = 1'b0;
            hold_left = 5;
        end
        if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else if (ready_mode == 0) begin
            out_ready = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit rl);
        int n = 0;
        in_valid = 1'b1;
        d1 = a;
        d2 = b;
        relu = rl;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 50);
        chk("beat_accept", {63'd0, last_accept}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_result(input string tag, input logic [DL-1:0] exp);
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk(tag, {48'd0, q}, {48'd0, exp});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
    endtask

    task automatic send_unit_vector();
        send_beat(lane0(16'h0200), lane0(16'h0300), 1'b0);
        for (int b = 1; b < BT; b++) send_beat(zero_v, zero_v, 1'b0);
    endtask

    initial begin
        int seen0;
        bit rl;
        ones     = {LN{16'h0100}};
        zero_v   = '0;
        rst      = 1'b1;
        clear    = 1'b0;
        relu     = 1'b0;
        in_valid = 1'b0;
        d1       = '0;
        d2       = '0;
        out_ready = 1'b1;

        #2;
        chk("reset_q", {48'd0, q}, 64'd0);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Unit product with latency check
        send_unit_vector();
        chk("lat_edge_k", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lat_edge_k1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lat_edge_k2_valid", {63'd0, out_valid}, 64'd1);
        chk("unit_q", {48'd0, q}, 64'h0600);

        // Saturation
        for (int b = 0; b < BT; b++) send_beat(ones, ones, 1'b0);
        wait_result("sat_q", 16'h7FFF);

        // Negative result, then relu clamp
        send_beat(lane0(16'hFF00), lane0(16'h0100), 1'b0);
        for (int b = 1; b < BT; b++) send_beat(zero_v, zero_v, 1'b0);
        wait_result("neg_q", 16'hFF00);
        send_beat(lane0(16'hFF00), lane0(16'h0100), 1'b1);
        for (int b = 1; b < BT; b++) send_beat(zero_v, zero_v, 1'b1);
        wait_result("relu_q", 16'h0000);
        drain();

        // Back-to-back vectors with a 5-cycle sink stall after the first result
        stall_cycles = 0;
        seen0 = results_seen;
        arm_hold = 1'b1;
        for (int v = 0; v < 3; v++)
            for (int b = 0; b < BT; b++) send_beat(rand_vec(), rand_vec(), 1'b0);
        drain();
        chk("b2b_results", {32'd0, 32'(results_seen - seen0)}, 64'd3);
        chk("b2b_stall_cycles", {32'd0, 32'(stall_cycles)}, 64'd5);

        // Clear mid-vector while a finished result is held
        ready_mode = 2;
        out_ready  = 1'b0;
        send_beat(lane0(16'hFF00), lane0(16'h0100), 1'b0);
        for (int b = 1; b < BT; b++) send_beat(zero_v, zero_v, 1'b0);
        send_beat(rand_vec(), rand_vec(), 1'b0);
        send_beat(rand_vec(), rand_vec(), 1'b0);
        idle(2);
        chk("held_valid", {63'd0, out_valid}, 64'd1);
        chk("held_q", {48'd0, q}, 64'hFF00);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_keeps_valid", {63'd0, out_valid}, 64'd1);
        chk("clear_keeps_q", {48'd0, q}, 64'hFF00);
        out_ready  = 1'b1;
        ready_mode = 0;
        tick();
        send_unit_vector();
        wait_result("after_clear_q", 16'h0600);
        drain();

        // Reset mid-vector
        send_beat(rand_vec(), rand_vec(), 1'b0);
        send_beat(rand_vec(), rand_vec(), 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst_q", {48'd0, q}, 64'd0);
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        tick();
        rst = 1'b0;
        send_unit_vector();
        wait_result("after_rst_q", 16'h0600);
        drain();

        // Randomized vectors, bubbles, sink back-pressure and relu
        ready_mode = 1;
        seen0 = results_seen;
        for (int v = 0; v < 30; v++) begin
            rl = $urandom_range(0, 1);
            for (int b = 0; b < BT; b++) begin
                send_beat(rand_vec(), rand_vec(), (b == BT - 1) ? rl : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        ready_mode = 0;
        drain();
        chk("random_results", {32'd0, 32'(results_seen - seen0)}, 64'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
